segment_capture: RTL and testbench
==================================

# segment_capture

Multi-digit 7-segment bus capture and encoder: it watches a time-multiplexed, active-low 7-segment display bus (pattern plus one-hot digit select) and recovers the 4-bit hex value shown on each digit. It is the receiving end of the display path, performing segment pattern → hex, and sits between a display bus tap and the CPU debug/verification logic. It filters glitches with a stability counter, stores one nibble per digit and reports each new capture with a one-cycle pulse.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (1–8).
- STABLE_CYCLES, 3: consecutive matching cycles required before a capture is accepted (≥1).
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- segIn  in  [0:6]  active-low segment pattern; segIn[0]=g … segIn[6]=a (bit 0 is the MSB of the 7-bit literal).
- digitSel  in  NUM_DIGITS  one-hot, active-high digit select.
- hexOut  out  4*NUM_DIGITS  captured nibbles; digit i occupies bits [4i+3:4i].
- digitValid  out  NUM_DIGITS  sticky flag, set when digit i has been captured at least once.
- newValue  out  1  one-cycle pulse on each accepted capture.
- newIndex  out  3  digit index of the capture; valid while newValue=1.
- newHex  out  4  captured nibble; valid while newValue=1.
- patternError  out  1  one-cycle pulse when a stable pattern is not in the table.

## Operation
- Input stage: segIn and digitSel are registered every edge into sPat and sSel. The FSM uses only these registered copies.
- Pattern table (segIn[0:6], active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blank pattern 1111111 means the digit is off. It is never captured and is not an error.
- A sample is "eligible" when sSel is exactly one-hot and sPat ≠ 1111111.
- FSM states and transitions:
  - IDLE: on an eligible sample, load heldPat/heldSel and set count=1 → COUNT. Otherwise stay.
  - COUNT: an ineligible sample → IDLE.
  - COUNT: an eligible sample different from held → reload held, count=1, stay in COUNT.
  - COUNT: a sample equal to held with count<STABLE_CYCLES → count+1.
  - COUNT: a sample equal to held with count==STABLE_CYCLES → act on the pattern, then go to DONE.
    - Pattern in table: write the nibble into hexOut for that digit, set digitValid[i], pulse newValue with newIndex/newHex.
    - Pattern not in table: pulse patternError only; no register changes.
  - DONE: hold while samples equal held, with no further pulses. An ineligible sample → IDLE. An eligible, different sample → reload held, count=1 → COUNT.
- Width rules:
  - count is $clog2(STABLE_CYCLES+1) bits and saturates by construction.
  - newIndex is the binary encoding of heldSel, zero-extended to 3 bits.
- newValue and patternError are mutually exclusive.

## Timing
- Reset values:
  - hexOut = 0, digitValid = 0, newValue = 0, newIndex = 0, newHex = 0, patternError = 0.
  - sPat = 1111111, sSel = 0, FSM = IDLE, count = 0.
- Latency:
  - A pattern and select are first sampled at edge N and stay stable.
  - Counting starts at edge N+1 (count=1).
  - The capture happens at edge N+STABLE_CYCLES+1.
  - newValue (or patternError) is high for exactly the cycle that follows that edge.
  - hexOut and digitValid are updated at that same edge.
- Any change to the pattern or select before the capture edge restarts counting; there is no partial credit.
- Re-presenting the same digit with the same value after it has passed through IDLE produces a new pulse.
- Reset asserted mid-count or in DONE: everything returns to reset values at that edge, and any pending capture is discarded.

## Test plan
- Reset then idle: reset high for 2 cycles, then segIn=1111111 and digitSel=0001 for 20 cycles → all outputs stay 0.
- Basic capture (STABLE_CYCLES=3): segIn=0010010 (5) and digitSel=0100, stable from edge N.
  - newValue pulses one cycle after edge N+4 with newIndex=2, newHex=5.
  - hexOut=16'h0500 and digitValid=0100 from then on.
  - Holding the inputs for 50 more cycles produces no second pulse.
- Glitch rejection: apply 0000000 for 2 cycles, then 1111001 for 4 cycles, on digitSel=0001.
  - Exactly one pulse, with newHex=1 and newIndex=0.
  - No capture of 8.
- Invalid pattern: segIn=0101010, digitSel=1000, stable for 5 cycles.
  - patternError pulses once.
  - newValue stays 0; hexOut and digitValid are unchanged.
- Multiplex scan: cycle through digits 0..3 showing A, b, C, d, 6 cycles each, separated by 1 blank cycle.
  - Four newValue pulses, with indices 0,1,2,3.
  - hexOut=16'hDCBA and digitValid=1111.
  - Illegal select digitSel=0110 for 6 cycles causes no capture.
- Reset mid-operation: assert reset at count=2 of a pending 7 on digit 1 → no pulse, and hexOut=0.

Source files
------------

// File: rtl/segment_capture.sv
// Recovers hex digits from a multiplexed active-low 7-segment display bus.
// Each digit must be held stable for STABLE_CYCLES samples before it is captured.
module segment_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [0:6]              segIn,
  input  logic [NUM_DIGITS-1:0]   digitSel,
  output logic [4*NUM_DIGITS-1:0] hexOut,
  output logic [NUM_DIGITS-1:0]   digitValid,
  output logic                    newValue,
  output logic [2:0]              newIndex,
  output logic [3:0]              newHex,
  output logic                    patternError
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]         CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_ZERO = CW'(0);
  localparam logic [0:6]            BLANK    = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] SEL_ZERO = NUM_DIGITS'(0);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Returns {known, nibble}; known=0 for patterns outside the hex table.
  function automatic logic [4:0] decode(input logic [0:6] pat);
    case (pat)
      7'b1000000: decode = {1'b1, 4'h0};
      7'b1111001: decode = {1'b1, 4'h1};
      7'b0100100: decode = {1'b1, 4'h2};
      7'b0110000: decode = {1'b1, 4'h3};
      7'b0011001: decode = {1'b1, 4'h4};
      7'b0010010: decode = {1'b1, 4'h5};
      7'b0000010: decode = {1'b1, 4'h6};
      7'b1111000: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0010000: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b0000011: decode = {1'b1, 4'hB};
      7'b1000110: decode = {1'b1, 4'hC};
      7'b0100001: decode = {1'b1, 4'hD};
      7'b0000110: decode = {1'b1, 4'hE};
      7'b0001110: decode = {1'b1, 4'hF};
      default:    decode = 5'b00000;
    endcase
  endfunction

  function automatic logic [2:0] encode(input logic [NUM_DIGITS-1:0] sel);
    encode = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) encode = 3'(i);
    end
  endfunction

  logic [0:6]              r_spat;
  logic [NUM_DIGITS-1:0]   r_ssel;
  logic [0:6]              r_held_pat;
  logic [NUM_DIGITS-1:0]   r_held_sel;
  logic [CW-1:0]           r_count;
  state_t                  r_state;
  logic [4*NUM_DIGITS-1:0] r_hex;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic                    r_new_value;
  logic [2:0]              r_new_index;
  logic [3:0]              r_new_hex;
  logic                    r_pattern_error;

  logic       w_onehot;
  logic       w_eligible;
  logic       w_same;
  logic [4:0] w_decoded;

  assign w_onehot   = (r_ssel != SEL_ZERO) && ((r_ssel & (r_ssel - SEL_ONE)) == SEL_ZERO);
  assign w_eligible = w_onehot && (r_spat != BLANK);
  assign w_same     = (r_spat == r_held_pat) && (r_ssel == r_held_sel);
  assign w_decoded  = decode(r_held_pat);

  // Input sampling, stability FSM and capture registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_spat          <= BLANK;
      r_ssel          <= SEL_ZERO;
      r_held_pat      <= BLANK;
      r_held_sel      <= SEL_ZERO;
      r_count         <= CNT_ZERO;
      r_state         <= ST_IDLE;
      r_hex           <= {(4*NUM_DIGITS){1'b0}};
      r_valid         <= SEL_ZERO;
      r_new_value     <= 1'b0;
      r_new_index     <= 3'd0;
      r_new_hex       <= 4'h0;
      r_pattern_error <= 1'b0;
    end else begin
      r_spat          <= segIn;
      r_ssel          <= digitSel;
      r_new_value     <= 1'b0;
      r_pattern_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_eligible) begin
            r_held_pat <= r_spat;
            r_held_sel <= r_ssel;
            r_count    <= CNT_ONE;
            r_state    <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!w_eligible) begin
            r_count <= CNT_ZERO;
            r_state <= ST_IDLE;
          end else if (!w_same) begin
            r_held_pat <= r_spat;
            r_held_sel <= r_ssel;
            r_count    <= CNT_ONE;
          end else if (r_count != CNT_MAX) begin
            r_count <= r_count + CNT_ONE;
          end else begin
            // Stable long enough: capture known patterns, flag unknown ones.
            if (w_decoded[4]) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (r_held_sel[i]) r_hex[4*i +: 4] <= w_decoded[3:0];
              end
              r_valid     <= r_valid | r_held_sel;
              r_new_value <= 1'b1;
              r_new_index <= encode(r_held_sel);
              r_new_hex   <= w_decoded[3:0];
            end else begin
              r_pattern_error <= 1'b1;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!w_eligible) begin
            r_count <= CNT_ZERO;
            r_state <= ST_IDLE;
          end else if (!w_same) begin
            r_held_pat <= r_spat;
            r_held_sel <= r_ssel;
            r_count    <= CNT_ONE;
            r_state    <= ST_COUNT;
          end
        end
        default: begin
          r_count <= CNT_ZERO;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign hexOut       = r_hex;
  assign digitValid   = r_valid;
  assign newValue     = r_new_value;
  assign newIndex     = r_new_index;
  assign newHex       = r_new_hex;
  assign patternError = r_pattern_error;

endmodule

// File: tb/tb_segment_capture.sv
// Directed, table-driven bench for segment_capture (4 digits, 3 stable cycles).
module tb_segment_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic [0:6]  segIn;
  logic [3:0]  digitSel;
  logic [15:0] hexOut;
  logic [3:0]  digitValid;
  logic        newValue;
  logic [2:0]  newIndex;
  logic [3:0]  newHex;
  logic        patternError;

  segment_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clock(clock), .reset(reset), .segIn(segIn), .digitSel(digitSel),
    .hexOut(hexOut), .digitValid(digitValid), .newValue(newValue),
    .newIndex(newIndex), .newHex(newHex), .patternError(patternError)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [0:6]  seg;
    logic [3:0]  sel;
    logic        nv;
    logic        pe;
    logic        chk_nx;
    logic [2:0]  idx;
    logic [3:0]  nh;
    logic [15:0] hex;
    logic [3:0]  valid;
  } vec_t;

  vec_t        vq[$];
  logic [15:0] e_hex;
  logic [3:0]  e_valid;
  int          n_vec = 0;
  int          n_bad = 0;

  localparam logic [0:6] BL = 7'b1111111;

  task automatic add(input logic rst, input logic [0:6] seg, input logic [3:0] sel,
                     input logic nv, input logic pe, input logic [2:0] idx, input logic [3:0] nh);
    vec_t v;
    if (rst) begin
      e_hex   = 16'h0000;
      e_valid = 4'b0000;
    end
    v.rst = rst; v.seg = seg; v.sel = sel; v.nv = nv; v.pe = pe;
    v.chk_nx = nv | rst; v.idx = idx; v.nh = nh; v.hex = e_hex; v.valid = e_valid;
    vq.push_back(v);
  endtask

  // A run of identical samples; pulse_at is the vector index where the pulse is seen (-1: none).
  task automatic run(input logic [0:6] seg, input logic [3:0] sel, input int len, input int pulse_at,
                     input logic is_err, input logic [2:0] idx, input logic [3:0] nh,
                     input logic [15:0] hex_after, input logic [3:0] valid_after);
    for (int i = 0; i < len; i++) begin
      if (i == pulse_at) begin
        e_hex   = hex_after;
        e_valid = valid_after;
        add(1'b0, seg, sel, !is_err, is_err, idx, nh);
      end else begin
        add(1'b0, seg, sel, 1'b0, 1'b0, 3'd0, 4'h0);
      end
    end
  endtask

  task automatic blanks(input int len);
    run(BL, 4'b0000, len, -1, 1'b0, 3'd0, 4'h0, 16'h0000, 4'b0000);
  endtask

  initial begin
    int lat;
    int pulses;
    reset = 1'b1; segIn = BL; digitSel = 4'b0000;
    e_hex = 16'h0000; e_valid = 4'b0000;

    add(1'b1, BL, 4'b0000, 1'b0, 1'b0, 3'd0, 4'h0);
    add(1'b1, BL, 4'b0000, 1'b0, 1'b0, 3'd0, 4'h0);
    run(BL, 4'b0001, 20, -1, 1'b0, 3'd0, 4'h0, 16'h0000, 4'b0000);
    // digit 2 shows 5, then held 50 more cycles with no repeat pulse
    run(7'b0010010, 4'b0100, 55, 4, 1'b0, 3'd2, 4'h5, 16'h0500, 4'b0100);
    // 8 for two samples only, then 1 for four; the 1 is captured on the following edge
    run(7'b0000000, 4'b0001, 2, -1, 1'b0, 3'd0, 4'h0, 16'h0000, 4'b0000);
    run(7'b1111001, 4'b0001, 4, -1, 1'b0, 3'd0, 4'h0, 16'h0000, 4'b0000);
    e_hex = 16'h0501; e_valid = 4'b0101;
    add(1'b0, BL, 4'b0001, 1'b1, 1'b0, 3'd0, 4'h1);
    blanks(2);
    run(7'b0101010, 4'b1000, 5, 4, 1'b1, 3'd0, 4'h0, 16'h0501, 4'b0101);
    blanks(2);
    run(7'b0001000, 4'b0001, 6, 4, 1'b0, 3'd0, 4'hA, 16'h050A, 4'b0101);
    blanks(1);
    run(7'b0000011, 4'b0010, 6, 4, 1'b0, 3'd1, 4'hB, 16'h05BA, 4'b0111);
    blanks(1);
    run(7'b1000110, 4'b0100, 6, 4, 1'b0, 3'd2, 4'hC, 16'h0CBA, 4'b0111);
    blanks(1);
    run(7'b0100001, 4'b1000, 6, 4, 1'b0, 3'd3, 4'hD, 16'hDCBA, 4'b1111);
    blanks(1);
    run(7'b0001000, 4'b0110, 6, -1, 1'b0, 3'd0, 4'h0, 16'h0000, 4'b0000);
    blanks(2);
    // reset while a 7 on digit 1 is at count 2
    run(7'b1111000, 4'b0010, 3, -1, 1'b0, 3'd0, 4'h0, 16'h0000, 4'b0000);
    add(1'b1, 7'b1111000, 4'b0010, 1'b0, 1'b0, 3'd0, 4'h0);
    blanks(4);
    // same digit and value twice, separated by a blank: two pulses
    run(7'b1111000, 4'b0010, 5, 4, 1'b0, 3'd1, 4'h7, 16'h0070, 4'b0010);
    blanks(1);
    run(7'b1111000, 4'b0010, 5, 4, 1'b0, 3'd1, 4'h7, 16'h0070, 4'b0010);
    blanks(3);

    foreach (vq[k]) begin
      @(negedge clock);
      reset = vq[k].rst; segIn = vq[k].seg; digitSel = vq[k].sel;
      @(posedge clock);
      #1;
      n_vec++;
      if (newValue !== vq[k].nv || patternError !== vq[k].pe || hexOut !== vq[k].hex ||
          digitValid !== vq[k].valid ||
          (vq[k].chk_nx && (newIndex !== vq[k].idx || newHex !== vq[k].nh))) begin
        n_bad++;
        $display("FAIL vec%0d: got nv=%b pe=%b idx=%0d nib=%h hex=%h valid=%b, want nv=%b pe=%b idx=%0d nib=%h hex=%h valid=%b",
                 k, newValue, patternError, newIndex, newHex, hexOut, digitValid,
                 vq[k].nv, vq[k].pe, vq[k].idx, vq[k].nh, vq[k].hex, vq[k].valid);
      end
    end

    // Three stable samples are one short of a capture.
    pulses = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      reset = 1'b0;
      segIn = (c <= 3) ? 7'b0010000 : BL;
      digitSel = 4'b0001;
      @(posedge clock);
      #1;
      if (newValue || patternError) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL short_run: got %0d pulses, want 0", pulses);
    end

    // Four stable samples: pulse seen after the fifth edge.
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      segIn = (c <= 4) ? 7'b0010000 : BL;
      digitSel = 4'b0001;
      @(posedge clock);
      #1;
      if (newValue && patternError) begin
        n_vec++; n_bad++;
        $display("FAIL exclusive: got both pulses at cycle %0d, want at most one", c);
      end
      if (newValue && lat == 0) lat = c;
    end
    n_vec++;
    if (lat != 5) begin
      n_bad++;
      $display("FAIL latency: got %0d, want 5", lat);
    end
    n_vec++;
    if (hexOut !== 16'h0079 || digitValid !== 4'b0011) begin
      n_bad++;
      $display("FAIL final_regs: got hex=%h valid=%b, want hex=0079 valid=0011", hexOut, digitValid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
